param_main_memory: RTL and testbench

Parametrised successor to the fixed 32-byte-block main memory. It serves block refills and writebacks for the cache and generalises the following:
- block size
- memory depth
- separate read and write latencies

It adds per-word write masking (partial writebacks) and an out-of-range error response. It sits behind the cache controller's memory port; the handshake stays compatible (req/ready in, one-cycle resp pulse out).

---
 rtl/cache_pkg.sv | 16 +
 rtl/mem_latency_ctr.sv | 24 ++
 rtl/param_main_memory.sv | 126 ++++++++++++
 tb/tb_param_main_memory.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: word width, default memory geometry and timing,
// and the main-memory controller state encoding.
package cache_pkg;

  localparam int WORD_BITS       = 32;
  localparam int MEM_BLOCK_WORDS = 8;
  localparam int MEM_RD_LATENCY  = 4;
  localparam int MEM_WR_LATENCY  = 4;
  localparam int LAT_CTR_W       = 4;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1
  } mem_state_t;

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable latency down-counter; saturates at zero and flags it.
module mem_latency_ctr
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CTR_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [LAT_CTR_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                     count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - LAT_CTR_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/param_main_memory.sv
// Block-oriented main memory with configurable block size, depth and read/write
// latencies, per-word write masking and an out-of-range error response.
module param_main_memory
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
  parameter int MEM_WORDS   = 16384,
  parameter int RD_LATENCY  = MEM_RD_LATENCY,
  parameter int WR_LATENCY  = MEM_WR_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_req,
  input  logic                             mem_rw,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [BLOCK_WORDS*WORD_BITS-1:0] mem_wdata,
  input  logic [BLOCK_WORDS-1:0]           mem_wmask,
  output logic                             mem_ready,
  output logic                             mem_resp,
  output logic                             mem_err,
  output logic [BLOCK_WORDS*WORD_BITS-1:0] mem_rdata
);

  localparam int OFF_W    = $clog2(BLOCK_WORDS * WORD_BITS / 8);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int BLK_BITS = BLOCK_WORDS * WORD_BITS;

  typedef logic [WORD_BITS-1:0] mem_array_t [MEM_WORDS];

  // Power-up image: every word holds its own byte address.
  function automatic mem_array_t init_image();
    mem_array_t img;
    for (int i = 0; i < MEM_WORDS; i++) img[i] = WORD_BITS'(i * 4);
    return img;
  endfunction

  mem_array_t mem = init_image();

  mem_state_t              state;
  logic                    rw_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BLK_BITS-1:0]     wdata_q;
  logic [BLOCK_WORDS-1:0]  wmask_q;
  logic                    accept, done, ctr_zero, in_range;
  logic [ADDR_WIDTH-3:0]   base_word;
  logic [IDX_W-1:0]        base_idx;
  logic [BLK_BITS-1:0]     rd_block;
  logic                    unused_addr_bits;

  assign accept    = (state == M_IDLE) && mem_req && mem_ready;
  assign done      = (state == M_WAIT) && ctr_zero;
  assign base_word = addr_q[ADDR_WIDTH-1:2];
  assign base_idx  = base_word[IDX_W-1:0];
  assign in_range  = (64'(base_word) + 64'(BLOCK_WORDS)) <= 64'(MEM_WORDS);
  assign unused_addr_bits = ^addr_q[1:0];

  mem_latency_ctr u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (mem_rw ? LAT_CTR_W'(WR_LATENCY - 1) : LAT_CTR_W'(RD_LATENCY - 1)),
    .dec      (state == M_WAIT),
    .zero     (ctr_zero)
  );

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_block = '0;
    for (int k = 0; k < BLOCK_WORDS; k++)
      rd_block[k*WORD_BITS +: WORD_BITS] = mem[base_idx + IDX_W'(k)];
  end

  // Request capture needs no reset: it is only consumed after an acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= mem_rw;
      addr_q  <= mem_addr & ~ADDR_WIDTH'((1 << OFF_W) - 1);
      wdata_q <= mem_wdata;
      wmask_q <= mem_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= M_IDLE;
      mem_ready <= 1'b1;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        M_IDLE: begin
          if (accept) begin
            mem_ready <= 1'b0;
            state     <= M_WAIT;
          end
        end
        M_WAIT: begin
          if (ctr_zero) begin
            mem_resp  <= 1'b1;
            mem_err   <= !in_range;
            mem_ready <= 1'b1;
            state     <= M_IDLE;
            if (!rw_q) mem_rdata <= in_range ? rd_block : '0;
          end
        end
        default: begin
          mem_ready <= 1'b1;
          state     <= M_IDLE;
        end
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && done && rw_q && in_range) begin
      for (int k = 0; k < BLOCK_WORDS; k++)
        if (wmask_q[k]) mem[base_idx + IDX_W'(k)] <= wdata_q[k*WORD_BITS +: WORD_BITS];
    end
  end

endmodule

// File: tb/tb_param_main_memory.sv
// Bench for param_main_memory: two instances (default timing, and RD=2/WR=6)
// checked against a word-array reference model driven by directed and random requests.
module tb_param_main_memory;

  localparam int BW = 8;
  localparam int MW = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req   [2];
  logic         rw    [2];
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic [7:0]   wmask [2];
  logic         ready [2];
  logic         resp  [2];
  logic         err   [2];
  logic [255:0] rdata [2];

  int rd_lat [2] = '{4, 2};
  int wr_lat [2] = '{4, 6};

  logic [31:0]  model   [2][MW];
  logic [255:0] last_rd [2];

  int total = 0;
  int bad   = 0;

  param_main_memory u_dut0 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_rw(rw[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wmask(wmask[0]), .mem_ready(ready[0]),
    .mem_resp(resp[0]), .mem_err(err[0]), .mem_rdata(rdata[0])
  );

  param_main_memory #(.RD_LATENCY(2), .WR_LATENCY(6)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_rw(rw[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wmask(wmask[1]), .mem_ready(ready[1]),
    .mem_resp(resp[1]), .mem_err(err[1]), .mem_rdata(rdata[1])
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    for (int k = 0; k < BW; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // One request on instance d, starting at a negedge with the instance idle.
  // Returns at the negedge of the response cycle, so a back-to-back request may follow.
  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [255:0] wd, input logic [7:0] wm);
    int       lat, seen;
    longint   base;
    bit       oor;
    logic [255:0] exp_rd;
    lat  = w ? wr_lat[d] : rd_lat[d];
    base = longint'(a & ~32'(BW*4 - 1)) >> 2;
    oor  = (base + BW) > MW;

    check($sformatf("ready_before_req_d%0d", d), 256'(ready[d]), 256'(1));
    req[d] = 1'b1; rw[d] = w; addr[d] = a; wdata[d] = wd; wmask[d] = wm;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs once the request is gone: the DUT must have latched them.
    req[d] = 1'b0; rw[d] = ~w; addr[d] = $urandom; wdata[d] = rand_block(); wmask[d] = 8'($urandom);

    seen = -1;
    for (int i = 0; i <= 20 && seen < 0; i++) begin
      if (resp[d] === 1'b1) seen = i;
      else @(negedge clk);
    end
    check($sformatf("latency_d%0d_%s_%h", d, w ? "wr" : "rd", a), 256'(seen), 256'(lat));
    check($sformatf("err_d%0d_%h", d, a), 256'(err[d]), 256'(oor));

    if (!w) begin
      exp_rd = '0;
      if (!oor) for (int k = 0; k < BW; k++) exp_rd[k*32 +: 32] = model[d][int'(base) + k];
      check($sformatf("rdata_d%0d_%h", d, a), rdata[d], exp_rd);
      last_rd[d] = exp_rd;
    end else begin
      check($sformatf("rdata_hold_d%0d_%h", d, a), rdata[d], last_rd[d]);
      if (!oor)
        for (int k = 0; k < BW; k++)
          if (wm[k]) model[d][int'(base) + k] = wd[k*32 +: 32];
    end
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    check($sformatf("pulse_end_d%0d", d), {253'd0, resp[d], err[d], ready[d]}, 256'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] blk;
    int           rcnt;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MW; i++) model[d][i] = 32'(i * 4);
      req[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wmask[d] = '0;
      last_rd[d] = '0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ctl_d%0d", d), {253'd0, ready[d], resp[d], err[d]}, 256'b100);
      check($sformatf("reset_rdata_d%0d", d), rdata[d], '0);
    end

    // Basic read, then unaligned read of the same block.
    txn(0, 1'b0, 32'h0000_0040, '0, '0);
    check("read40_word0", 256'(rdata[0][31:0]), 256'(32'h40));
    check("read40_word7", 256'(rdata[0][255:224]), 256'(32'h5C));
    idle_check(0);
    txn(0, 1'b0, 32'h0000_004C, '0, '0);
    idle_check(0);

    // Masked partial write, then read back.
    txn(0, 1'b1, 32'h0000_0100, {8{32'hA5A5_A5A5}}, 8'h81);
    idle_check(0);
    txn(0, 1'b0, 32'h0000_0100, '0, '0);
    check("masked_word1", 256'(rdata[0][63:32]), 256'(32'h104));
    check("masked_word7", 256'(rdata[0][255:224]), 256'(32'hA5A5_A5A5));
    idle_check(0);

    // Out-of-range read, then the last in-range block.
    txn(0, 1'b0, 32'h0001_0000, '0, '0);
    idle_check(0);
    txn(0, 1'b0, 32'h0000_FFE0, '0, '0);
    check("edge_word0", 256'(rdata[0][31:0]), 256'(32'hFFE0));
    idle_check(0);

    // Out-of-range write must not alias into the array.
    txn(0, 1'b1, 32'h0001_0000, {8{32'hDEAD_BEEF}}, 8'hFF);
    idle_check(0);
    txn(0, 1'b0, 32'h0000_0000, '0, '0);
    idle_check(0);

    // Reset two cycles into a write abandons it.
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h0000_0200; wdata[0] = {8{32'h1234_5678}}; wmask[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctl", {253'd0, ready[0], resp[0], err[0]}, 256'b100);
    check("midrst_rdata", rdata[0], '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp[0] === 1'b1) rcnt++;
    end
    check("midrst_no_resp", 256'(rcnt), 256'(0));
    txn(0, 1'b0, 32'h0000_0200, '0, '0);
    check("midrst_unwritten", 256'(rdata[0][31:0]), 256'(32'h200));
    idle_check(0);

    // Asymmetric latencies, read issued on the write's response cycle.
    blk = rand_block();
    txn(1, 1'b1, 32'h0000_0300, blk, 8'hFF);
    txn(1, 1'b0, 32'h0000_0300, '0, '0);
    check("b2b_readback", rdata[1], blk);
    idle_check(1);

    // Random traffic on both instances, with occasional back-to-back issue.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        int          sel;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      a = $urandom;
        else if (sel == 1) a = 32'h0000_FFC0 + 32'($urandom_range(0, 32'h7F));
        else               a = 32'($urandom_range(0, 32'h3FF));
        txn(d, 1'($urandom), a, rand_block(), 8'($urandom));
        if ($urandom_range(0, 2) != 0) idle_check(d);
      end
      idle_check(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
